// File: rtl/harris_frame_sequencer.sv
// rtl/harris_frame_sequencer.sv - frame fetch/clear/tag controller for the 6x6 Harris window stage
module harris_frame_sequencer #(
    parameter int IMG_W   = 480,
    parameter int IMG_H   = 360,
    parameter int WIN     = 6,
    parameter int ADDR_W  = 18,
    parameter int PIX_W   = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       frame_count,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_rd_data,
    output logic              wg_reset,
    output logic [PIX_W-1:0]  pix_out,
    output logic              pix_valid,
    input  logic              win_valid_in,
    output logic [15:0]       win_row,
    output logic [15:0]       win_col,
    output logic              win_sof,
    output logic              win_eol,
    output logic              win_eof
);

    localparam int TOTAL = IMG_W * IMG_H;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  fetch_cnt;
    logic              pix_valid_q;
    logic              abort_clr_q;
    logic [15:0]       row_q;
    logic [15:0]       col_q;
    logic [WD_W-1:0]   wd_q;
    logic              error_q;
    logic [15:0]       frame_q;

    logic busy_st;
    logic tag_active;
    logic beat;
    logic col_last;
    logic row_last;
    logic eof_beat;
    logic last_addr;
    logic timeout;
    logic accept;

    always_comb begin
        busy_st    = (state_q == S_CLEAR) || (state_q == S_FETCH) || (state_q == S_DRAIN);
        tag_active = (state_q == S_FETCH) || (state_q == S_DRAIN);
        beat       = win_valid_in && tag_active;
        col_last   = (col_q == 16'(IMG_W - 1));
        row_last   = (row_q == 16'(IMG_H - WIN));
        eof_beat   = beat && col_last && row_last;
        last_addr  = (fetch_cnt == CNT_W'(TOTAL - 1));
        timeout    = (state_q == S_DRAIN) && !beat && (wd_q == WD_W'(TIMEOUT - 1));
        accept     = (state_q == S_IDLE) && start && !abort;
    end

    // abort overrides every other transition out of a busy state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_CLEAR;
            S_CLEAR: state_d = S_FETCH;
            S_FETCH: if (last_addr) state_d = S_DRAIN;
            S_DRAIN: begin
                if (eof_beat)     state_d = S_DONE;
                else if (timeout) state_d = S_IDLE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort && busy_st) state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            fetch_cnt   <= '0;
            pix_valid_q <= 1'b0;
            abort_clr_q <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            wd_q        <= '0;
            error_q     <= 1'b0;
            frame_q     <= '0;
        end else begin
            state_q     <= state_d;
            pix_valid_q <= mem_rd_en;
            abort_clr_q <= abort && busy_st;
            if (accept) begin
                base_q    <= base_addr;
                error_q   <= 1'b0;
                row_q     <= '0;
                col_q     <= '0;
                fetch_cnt <= '0;
            end
            if (state_q == S_FETCH) fetch_cnt <= fetch_cnt + 1'b1;
            if (beat) begin
                if (col_last) begin
                    col_q <= '0;
                    row_q <= row_q + 16'd1;
                end else begin
                    col_q <= col_q + 16'd1;
                end
            end
            if ((state_q == S_DRAIN) && !beat) wd_q <= wd_q + 1'b1;
            else                               wd_q <= '0;
            if (timeout && !abort) error_q <= 1'b1;
            if (state_q == S_DONE) frame_q <= frame_q + 16'd1;
        end
    end

    always_comb begin
        busy        = busy_st;
        done        = (state_q == S_DONE);
        error       = error_q;
        frame_count = frame_q;
        mem_rd_en   = (state_q == S_FETCH) && !abort;
        mem_addr    = mem_rd_en ? base_q + ADDR_W'(fetch_cnt) : '0;
        wg_reset    = reset || (state_q == S_CLEAR) || abort_clr_q;
        pix_valid   = pix_valid_q;
        pix_out     = pix_valid_q ? mem_rd_data : '0;
        win_row     = row_q;
        win_col     = col_q;
        win_sof     = beat && (row_q == 16'd0) && (col_q == 16'd0);
        win_eol     = beat && col_last;
        win_eof     = eof_beat;
    end

endmodule

// File: tb/tb_harris_frame_sequencer.sv
// tb/tb_harris_frame_sequencer.sv - directed bench for harris_frame_sequencer (IMG_H=8, TIMEOUT=64)
module tb_harris_frame_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [17:0] base_addr = '0;
    logic        busy, done, error;
    logic [15:0] frame_count;
    logic        mem_rd_en;
    logic [17:0] mem_addr;
    logic [7:0]  mem_rd_data = '0;
    logic        wg_reset;
    logic [7:0]  pix_out;
    logic        pix_valid;
    logic        win_valid_in;
    logic [15:0] win_row, win_col;
    logic        win_sof, win_eol, win_eof;

    harris_frame_sequencer #(
        .IMG_W(480), .IMG_H(8), .WIN(6), .ADDR_W(18), .PIX_W(8), .TIMEOUT(64)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .base_addr(base_addr),
        .busy(busy), .done(done), .error(error), .frame_count(frame_count),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .wg_reset(wg_reset), .pix_out(pix_out), .pix_valid(pix_valid),
        .win_valid_in(win_valid_in), .win_row(win_row), .win_col(win_col),
        .win_sof(win_sof), .win_eol(win_eol), .win_eof(win_eof)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_fc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM holds the low address byte; window stub fires on pixels of rows WIN-1..IMG_H-1
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem_addr[7:0];

    bit stub_en = 1'b1;
    int stub_cnt = 0;
    always @(posedge clk) begin
        if (reset || wg_reset) stub_cnt <= 0;
        else if (pix_valid)    stub_cnt <= stub_cnt + 1;
    end
    assign win_valid_in = stub_en && pix_valid && (stub_cnt >= 2400);

    bit          mon_clr = 1'b0;
    logic [17:0] mon_base = '0;
    logic [17:0] exp_addr = '0;
    logic        prev_rd = 1'b0;
    logic [7:0]  prev_addr8 = '0;
    logic        prev_err = 1'b0;
    int rd_cnt, addr_err, pix_cnt, pix_err, beat_idx, beat_cnt, tag_err;
    int sof_cnt, eol_cnt, eof_cnt, done_cnt, wg_cnt, eof_cyc, done_cyc, last_rd_cyc, err_cyc;

    always @(negedge clk) begin
        if (mon_clr) begin
            rd_cnt <= 0; addr_err <= 0; pix_cnt <= 0; pix_err <= 0; beat_idx <= 0;
            beat_cnt <= 0; tag_err <= 0; sof_cnt <= 0; eol_cnt <= 0; eof_cnt <= 0;
            done_cnt <= 0; wg_cnt <= 0; eof_cyc <= 0; done_cyc <= 0; last_rd_cyc <= 0;
            err_cyc <= 0;
        end else begin
            if (wg_reset) begin
                wg_cnt   <= wg_cnt + 1;
                beat_idx <= 0;
                exp_addr <= mon_base;
            end
            if (mem_rd_en) begin
                rd_cnt <= rd_cnt + 1;
                if (mem_addr !== exp_addr) addr_err <= addr_err + 1;
                exp_addr    <= exp_addr + 18'd1;
                last_rd_cyc <= cyc;
            end
            if (pix_valid) begin
                pix_cnt <= pix_cnt + 1;
                if (!prev_rd || pix_out !== prev_addr8) pix_err <= pix_err + 1;
            end
            if (win_valid_in) begin
                beat_idx <= beat_idx + 1;
                beat_cnt <= beat_cnt + 1;
                if (win_row !== 16'(beat_idx / 480) || win_col !== 16'(beat_idx % 480) ||
                    win_sof !== (beat_idx == 0) || win_eol !== (beat_idx % 480 == 479) ||
                    win_eof !== (beat_idx == 1439))
                    tag_err <= tag_err + 1;
            end else if (win_sof || win_eol || win_eof) begin
                tag_err <= tag_err + 1;
            end
            if (win_sof) sof_cnt <= sof_cnt + 1;
            if (win_eol) eol_cnt <= eol_cnt + 1;
            if (win_eof) begin
                eof_cnt <= eof_cnt + 1;
                eof_cyc <= cyc;
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (error && !prev_err) err_cyc <= cyc;
        end
        prev_rd    <= mem_rd_en;
        prev_addr8 <= mem_addr[7:0];
        prev_err   <= error;
    end

    task automatic clear_mon(input logic [17:0] b);
        @(posedge clk); #1;
        mon_base = b;
        mon_clr  = 1'b1;
        @(posedge clk); #1;
        mon_clr  = 1'b0;
    endtask

    task automatic start_frame(input logic [17:0] b);
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = b;
        @(posedge clk); #1;
        start = 1'b0;
        base_addr = 18'h3000;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if ({busy, done, error, frame_count, mem_rd_en, mem_addr, pix_out, pix_valid,
             win_row, win_col, win_sof, win_eol, win_eof} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b done=%b err=%b fc=%0d rd=%b addr=%h pv=%b", busy, done, error, frame_count, mem_rd_en, mem_addr, pix_valid);
        end
        checks++;
        if (wg_reset !== 1'b1) begin failures++; $display("FAIL reset_wg_reset: got %b expected 1", wg_reset); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (wg_reset !== 1'b0) begin failures++; $display("FAIL reset_release_wg: got %b expected 0", wg_reset); end
    endtask

    task automatic test_single_frame;
        bit ok;
        clear_mon(18'h100);
        start_frame(18'h100);
        wait_done(5000, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL single_done: no done within budget"); end
        exp_fc++;
        checks++;
        if (rd_cnt !== 3840 || addr_err !== 0) begin failures++; $display("FAIL single_addr: reads=%0d addr_errs=%0d expected 3840/0", rd_cnt, addr_err); end
        checks++;
        if (pix_cnt !== 3840 || pix_err !== 0) begin failures++; $display("FAIL single_pix: beats=%0d errs=%0d expected 3840/0", pix_cnt, pix_err); end
        checks++;
        if (beat_cnt !== 1440 || tag_err !== 0) begin failures++; $display("FAIL single_tags: beats=%0d tag_errs=%0d expected 1440/0", beat_cnt, tag_err); end
        checks++;
        if (sof_cnt !== 1 || eol_cnt !== 3 || eof_cnt !== 1) begin failures++; $display("FAIL single_flags: sof=%0d eol=%0d eof=%0d expected 1/3/1", sof_cnt, eol_cnt, eof_cnt); end
        checks++;
        if (done_cyc - eof_cyc !== 1) begin failures++; $display("FAIL single_done_lag: got %0d expected 1", done_cyc - eof_cyc); end
        checks++;
        if (busy !== 1'b0 || wg_cnt !== 1) begin failures++; $display("FAIL single_busy_wg: busy=%b wg=%0d expected 0/1", busy, wg_cnt); end
        @(negedge clk); #1;
        checks++;
        if (done !== 1'b0 || frame_count !== 16'(exp_fc)) begin failures++; $display("FAIL single_fc: done=%b fc=%0d expected 0/%0d", done, frame_count, exp_fc); end
    endtask

    task automatic test_back_to_back;
        bit ok1, ok2;
        clear_mon(18'h0);
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = 18'h0;
        wait_done(5000, ok1);
        wait_done(5000, ok2);
        @(posedge clk); #1;
        start = 1'b0;
        exp_fc += 2;
        checks++;
        if (!ok1 || !ok2) begin failures++; $display("FAIL b2b_done: first=%b second=%b expected 1/1", ok1, ok2); end
        checks++;
        if (wg_cnt !== 2 || done_cnt !== 2) begin failures++; $display("FAIL b2b_pulses: wg=%0d done=%0d expected 2/2", wg_cnt, done_cnt); end
        checks++;
        if (beat_cnt !== 2880 || tag_err !== 0 || sof_cnt !== 2 || eof_cnt !== 2) begin failures++; $display("FAIL b2b_tags: beats=%0d errs=%0d sof=%0d eof=%0d", beat_cnt, tag_err, sof_cnt, eof_cnt); end
        repeat (3) @(negedge clk); #1;
        checks++;
        if (frame_count !== 16'(exp_fc) || busy !== 1'b0 || addr_err !== 0) begin failures++; $display("FAIL b2b_fc: fc=%0d busy=%b addr_errs=%0d expected %0d/0/0", frame_count, busy, addr_err, exp_fc); end
    endtask

    task automatic test_abort;
        bit hit, ok;
        hit = 1'b0;
        clear_mon(18'h100);
        start_frame(18'h100);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk); #1;
            if (mem_rd_en && mem_addr == 18'h100 + 18'd1000) begin
                hit = 1'b1;
                break;
            end
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (!hit) begin failures++; $display("FAIL abort_reach_1000: address not reached"); end
        checks++;
        if (mem_rd_en !== 1'b0 || busy !== 1'b0 || wg_reset !== 1'b1 || pix_valid !== 1'b0) begin failures++; $display("FAIL abort_next_cycle: rd=%b busy=%b wg=%b pv=%b expected 0/0/1/0", mem_rd_en, busy, wg_reset, pix_valid); end
        @(negedge clk); #1;
        checks++;
        if (wg_reset !== 1'b0 || rd_cnt !== 1001) begin failures++; $display("FAIL abort_wg_len: wg=%b reads=%0d expected 0/1001", wg_reset, rd_cnt); end
        repeat (10) @(negedge clk); #1;
        checks++;
        if (done_cnt !== 0 || frame_count !== 16'(exp_fc)) begin failures++; $display("FAIL abort_no_done: dones=%0d fc=%0d expected 0/%0d", done_cnt, frame_count, exp_fc); end
        // restart near the top of the address space so the fetch wraps
        clear_mon(18'h3FF80);
        start_frame(18'h3FF80);
        wait_done(5000, ok);
        exp_fc++;
        @(negedge clk); #1;
        checks++;
        if (!ok || addr_err !== 0 || rd_cnt !== 3840 || pix_err !== 0 || tag_err !== 0) begin failures++; $display("FAIL abort_restart: done=%b addr_errs=%0d reads=%0d pix_errs=%0d tag_errs=%0d", ok, addr_err, rd_cnt, pix_err, tag_err); end
        checks++;
        if (frame_count !== 16'(exp_fc)) begin failures++; $display("FAIL abort_restart_fc: got %0d expected %0d", frame_count, exp_fc); end
    endtask

    task automatic test_timeout;
        bit ok;
        ok = 1'b0;
        stub_en = 1'b0;
        clear_mon(18'h0);
        start_frame(18'h0);
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk); #1;
            if (error) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL timeout_error: error never set"); end
        checks++;
        if (busy !== 1'b0 || err_cyc - last_rd_cyc !== 65) begin failures++; $display("FAIL timeout_timing: busy=%b lag=%0d expected 0/65", busy, err_cyc - last_rd_cyc); end
        repeat (4) @(negedge clk); #1;
        checks++;
        if (done_cnt !== 0 || frame_count !== 16'(exp_fc) || error !== 1'b1) begin failures++; $display("FAIL timeout_no_done: dones=%0d fc=%0d err=%b", done_cnt, frame_count, error); end
        stub_en = 1'b1;
    endtask

    task automatic test_start_ignored;
        bit ok;
        int wg_before, busy_seen;
        clear_mon(18'h200);
        start_frame(18'h200);
        @(negedge clk); #1;
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL start_clears_error: err=%b busy=%b expected 0/1", error, busy); end
        for (int i = 0; i < 100 && rd_cnt < 10; i++) begin
            @(negedge clk); #1;
        end
        start = 1'b1;
        base_addr = 18'h3000;
        repeat (5) @(posedge clk);
        #1 start = 1'b0;
        wait_done(5000, ok);
        exp_fc++;
        checks++;
        if (!ok || addr_err !== 0 || rd_cnt !== 3840 || wg_cnt !== 1) begin failures++; $display("FAIL start_in_fetch: done=%b addr_errs=%0d reads=%0d wg=%0d", ok, addr_err, rd_cnt, wg_cnt); end
        start = 1'b1;
        base_addr = 18'h1234;
        @(posedge clk); #1;
        start = 1'b0;
        wg_before = wg_cnt;
        busy_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (busy) busy_seen++;
        end
        checks++;
        if (busy_seen !== 0 || wg_cnt !== wg_before || frame_count !== 16'(exp_fc)) begin failures++; $display("FAIL start_in_done: busy_cycles=%0d wg=%0d fc=%0d expected 0/%0d/%0d", busy_seen, wg_cnt, frame_count, wg_before, exp_fc); end
    endtask

    task automatic test_mid_frame_reset;
        bit hit;
        hit = 1'b0;
        clear_mon(18'h0);
        start_frame(18'h0);
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk); #1;
            if (beat_idx >= 700) begin
                hit = 1'b1;
                break;
            end
        end
        reset = 1'b1;
        @(negedge clk); #1;
        exp_fc = 0;
        checks++;
        if (!hit) begin failures++; $display("FAIL mreset_reach_700: beat 700 not reached"); end
        checks++;
        if ({busy, done, error, frame_count, mem_rd_en, mem_addr, pix_out, pix_valid,
             win_row, win_col, win_sof, win_eol, win_eof} !== '0) begin
            failures++;
            $display("FAIL mreset_outputs: busy=%b fc=%0d rd=%b row=%0d col=%0d pv=%b", busy, frame_count, mem_rd_en, win_row, win_col, pix_valid);
        end
        checks++;
        if (wg_reset !== 1'b1) begin failures++; $display("FAIL mreset_wg: got %b expected 1", wg_reset); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (wg_reset !== 1'b0 || busy !== 1'b0 || frame_count !== 16'(exp_fc)) begin failures++; $display("FAIL mreset_release: wg=%b busy=%b fc=%0d expected 0/0/0", wg_reset, busy, frame_count); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_abort();
        test_timeout();
        test_start_ignored();
        test_mid_frame_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
